// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter in front of a single-port word RAM.
// Requester A (datapath MAR/MDR) and requester B (I/O loader) share the RAM.
// A granted access holds its strobe for ACC_CYCLES cycles, then the grantee
// receives a one-cycle ack. Both ACCESS and RESP must complete before the
// arbiter accepts another request.
// Optional feature: define RAM_ARB_ROUND_ROBIN_EN for round-robin tie
// breaking. Without it, A always wins a tie.
module ram_arbiter #(
  parameter int ACC_CYCLES = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        a_req,
  input  logic        a_wr,
  input  logic [8:0]  a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_ack,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_wr,
  input  logic [8:0]  b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic [31:0] b_rdata,
  output logic        ram_read,
  output logic        ram_write,
  output logic [8:0]  ram_address,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACC_CYCLES - 1);

  state_t      state_r;
  state_t      state_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_s;
  logic        wr_r;
  logic        grant_vld_s;
  logic        grant_s;
  logic        tie_b_s;
  logic        capture_s;
  logic        sel_wr_s;
  logic [8:0]  sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic        wr_s;
  logic        owner_s;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic        ptr_r;

  // Priority pointer: after every grant the other requester gets the next tie.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ptr_r <= 1'b0;
    end else if (grant_vld_s) begin
      ptr_r <= ~grant_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Tie winner comes from the pointer.
  always_comb begin
    tie_b_s = ptr_r;
  end
`else
  // Fixed priority: A wins every tie.
  always_comb begin
    tie_b_s = 1'b0;
  end
`endif

  // Next-state logic, arbitration and read-capture decision.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    grant_vld_s = 1'b0;
    grant_s     = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (a_req || b_req) begin
          grant_vld_s = 1'b1;
          grant_s     = (a_req && b_req) ? tie_b_s : b_req;
          cnt_s       = CNT_LOAD;
          state_s     = ACCESS;
        end else begin
          state_s     = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_r == 4'd0) begin
          state_s   = RESP;
          capture_s = ~wr_r;
        end else begin
          cnt_s     = cnt_r - 4'd1;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Mux the grantee's request fields and form the post-edge access type/owner.
  always_comb begin
    sel_wr_s    = a_wr;
    sel_addr_s  = a_addr;
    sel_wdata_s = a_wdata;
    if (grant_s) begin
      sel_wr_s    = b_wr;
      sel_addr_s  = b_addr;
      sel_wdata_s = b_wdata;
    end else begin
      sel_wr_s    = a_wr;
      sel_addr_s  = a_addr;
      sel_wdata_s = a_wdata;
    end
    if (grant_vld_s) begin
      wr_s    = sel_wr_s;
      owner_s = grant_s;
    end else begin
      wr_s    = wr_r;
      owner_s = owner;
    end
  end

  // State and cycle counter registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Latch the grantee's request at grant so later input changes are ignored.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_r        <= 1'b0;
      ram_address <= 9'd0;
      ram_wdata   <= 32'd0;
      owner       <= 1'b0;
    end else if (grant_vld_s) begin
      wr_r        <= sel_wr_s;
      ram_address <= sel_addr_s;
      ram_wdata   <= sel_wdata_s;
      owner       <= grant_s;
    end else begin
      wr_r        <= wr_r;
      ram_address <= ram_address;
      ram_wdata   <= ram_wdata;
      owner       <= owner;
    end
  end

  // Registered strobes, acks and busy, decoded from the upcoming state.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ram_read  <= (state_s == ACCESS) && !wr_s;
      ram_write <= (state_s == ACCESS) && wr_s;
      a_ack     <= (state_s == RESP) && !owner_s;
      b_ack     <= (state_s == RESP) && owner_s;
      busy      <= (state_s != IDLE);
    end
  end

  // Read data capture on the final ACCESS edge, into the grantee's register only.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      a_rdata <= 32'd0;
      b_rdata <= 32'd0;
    end else if (capture_s) begin
      if (owner) begin
        b_rdata <= ram_rdata;
      end else begin
        a_rdata <= ram_rdata;
      end
    end else begin
      a_rdata <= a_rdata;
      b_rdata <= b_rdata;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter. Three instances run in
// parallel with ACC_CYCLES = 2, 1 and 15, each with its own RAM model,
// requester drivers, transaction-level reference model and monitor.
module tb_ram_arbiter;

  typedef struct packed {
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic        scr;
  } txn_t;

  typedef struct {
    bit          who;
    bit          wr;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] ra;
    logic [31:0] rb;
    int          ackc;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   done_v [3];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
    total = total + 1;
    if (!ok) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    case (i)
      32'h012: return 32'hDEADBEEF;
      32'h010: return 32'h10101010;
      32'h020: return 32'h20202020;
      default: return 32'(i * 32'h9E3779B9) ^ 32'h5A5A0000;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gen_cfg
    localparam int ACC = (g == 0) ? 2 : ((g == 1) ? 1 : 15);

    logic        clr;
    logic        a_req, a_wr, b_req, b_wr;
    logic [8:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_ack, b_ack;
    logic [31:0] a_rdata, b_rdata;
    logic        ram_read, ram_write;
    logic [8:0]  ram_address;
    logic [31:0] ram_wdata;
    wire  [31:0] ram_rdata;
    logic        busy, owner;
    logic        init_req;

    logic [31:0] mem [0:511];
    logic [31:0] mdl_mem [0:511];
    bit          mdl_ptr;
    logic [31:0] mdl_ra, mdl_rb;
    exp_t        sb [$];
    txn_t        a_list [$];
    txn_t        b_list [$];
    exp_t        mon_e;
    int          run;

    ram_arbiter #(.ACC_CYCLES(ACC)) dut (
      .clk(clk), .clr(clr),
      .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata),
      .ram_read(ram_read), .ram_write(ram_write), .ram_address(ram_address),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .busy(busy), .owner(owner)
    );

    // RAM model: synchronous write, combinational read, Z when not reading.
    always @(posedge clk) begin
      if (init_req) begin
        for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
      end else if (ram_write) begin
        mem[ram_address] <= ram_wdata;
      end
    end
    assign ram_rdata = ram_read ? mem[ram_address] : 32'bz;

    task automatic c(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
      chk(ok, $sformatf("acc%0d_%s", ACC, nm), act, req);
    endtask

    task automatic add_a(input logic wr, input logic [8:0] addr, input logic [31:0] wd, input logic scr);
      txn_t x;
      x.wr = wr; x.addr = addr; x.wdata = wd; x.scr = scr;
      a_list.push_back(x);
    endtask

    task automatic add_b(input logic wr, input logic [8:0] addr, input logic [31:0] wd);
      txn_t x;
      x.wr = wr; x.addr = addr; x.wdata = wd; x.scr = 1'b0;
      b_list.push_back(x);
    endtask

    // Reference model: grant points are spaced ACC+2 cycles apart; at each point
    // every requester with work left is requesting, ties go by the priority rule.
    task automatic schedule();
      int t;
      int ia;
      int ib;
      t = cyc + 1;
      ia = 0;
      ib = 0;
      while (ia < a_list.size() || ib < b_list.size()) begin
        bit   pick;
        txn_t x;
        exp_t e;
        if (ia < a_list.size() && ib < b_list.size()) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
          pick = mdl_ptr;
`else
          pick = 1'b0;
`endif
        end else begin
          pick = (ib < b_list.size());
        end
        mdl_ptr = !pick;
        if (pick) begin
          x = b_list[ib];
          ib++;
        end else begin
          x = a_list[ia];
          ia++;
        end
        if (x.wr) mdl_mem[x.addr] = x.wdata;
        else if (pick) mdl_rb = mdl_mem[x.addr];
        else mdl_ra = mdl_mem[x.addr];
        e.who = pick; e.wr = x.wr; e.addr = x.addr; e.wdata = x.wdata;
        e.ra = mdl_ra; e.rb = mdl_rb; e.ackc = t + ACC;
        sb.push_back(e);
        t = t + ACC + 2;
      end
    endtask

    task automatic drive_a();
      for (int i = 0; i < a_list.size(); i++) begin
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        a_req = 1'b1; a_wr = a_list[i].wr; a_addr = a_list[i].addr; a_wdata = a_list[i].wdata;
        while (!got && n < 400) begin
          @(negedge clk);
          n++;
          if (a_ack) got = 1'b1;
          else if (a_list[i].scr && n == 1) a_addr = a_addr ^ 9'h030;
        end
        c(got, "a_ack_seen", got, 1);
        a_req = 1'b0;
        if (i + 1 < a_list.size()) @(negedge clk);
      end
    endtask

    task automatic drive_b();
      for (int i = 0; i < b_list.size(); i++) begin
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        b_req = 1'b1; b_wr = b_list[i].wr; b_addr = b_list[i].addr; b_wdata = b_list[i].wdata;
        while (!got && n < 400) begin
          @(negedge clk);
          n++;
          if (b_ack) got = 1'b1;
        end
        c(got, "b_ack_seen", got, 1);
        b_req = 1'b0;
        if (i + 1 < b_list.size()) @(negedge clk);
      end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with it idle.
    task automatic issue();
      schedule();
      fork
        drive_a();
        drive_b();
      join
      @(negedge clk);
      c(sb.size() == 0, "sb_drain", sb.size(), 0);
      c(busy == 1'b0, "busy_idle", busy, 0);
      sb.delete();
      a_list.delete();
      b_list.delete();
    endtask

    // Monitor: strobe checks against the in-flight transaction, ack checks pop it.
    initial begin
      run = 0;
      forever begin
        @(negedge clk);
        c(!(ram_read && ram_write), "strobe_excl", {ram_read, ram_write}, 0);
        c(!(a_ack && b_ack), "ack_excl", {a_ack, b_ack}, 0);
        if (ram_read || ram_write) begin
          run++;
          if (sb.size() == 0) begin
            c(1'b0, "strobe_unexpected", {ram_read, ram_write}, 0);
          end else begin
            c(ram_write == sb[0].wr && ram_read == !sb[0].wr, "strobe_type",
              {ram_read, ram_write}, {!sb[0].wr, sb[0].wr});
            c(ram_address == sb[0].addr, "ram_address", ram_address, sb[0].addr);
            c(ram_wdata == sb[0].wdata, "ram_wdata", ram_wdata, sb[0].wdata);
          end
        end else if (run != 0) begin
          c(run == ACC, "strobe_width", run, ACC);
          run = 0;
        end
        if (a_ack || b_ack) begin
          if (sb.size() == 0) begin
            c(1'b0, "unexpected_ack", {a_ack, b_ack}, 0);
          end else begin
            mon_e = sb.pop_front();
            c(b_ack == mon_e.who, "ack_who", {a_ack, b_ack}, mon_e.who ? 2'b01 : 2'b10);
            c(cyc == mon_e.ackc, "ack_cycle", cyc, mon_e.ackc);
            c(a_rdata == mon_e.ra, "a_rdata", a_rdata, mon_e.ra);
            c(b_rdata == mon_e.rb, "b_rdata", b_rdata, mon_e.rb);
            c(owner == mon_e.who, "owner", owner, mon_e.who);
            c(busy == 1'b1, "busy_resp", busy, 1);
          end
        end
      end
    end

    // Stimulus sequence for this configuration.
    initial begin
      clr = 1'b1;
      a_req = 1'b0; a_wr = 1'b0; a_addr = 9'd0; a_wdata = 32'd0;
      b_req = 1'b0; b_wr = 1'b0; b_addr = 9'd0; b_wdata = 32'd0;
      init_req = 1'b1;
      mdl_ptr = 1'b0; mdl_ra = 32'd0; mdl_rb = 32'd0;
      for (int i = 0; i < 512; i++) mdl_mem[i] = init_word(i);
      #1 clr = 1'b0;
      repeat (3) @(negedge clk);
      c({ram_read, ram_write, a_ack, b_ack, busy, owner} == 6'b0, "reset_ctrl",
        {ram_read, ram_write, a_ack, b_ack, busy, owner}, 0);
      c(ram_address == 9'd0 && ram_wdata == 32'd0, "reset_bus", {ram_address, ram_wdata}, 0);
      c(a_rdata == 32'd0 && b_rdata == 32'd0, "reset_rdata", {a_rdata, b_rdata}, 0);
      init_req = 1'b0;
      clr = 1'b1;
      @(negedge clk);

      // A read of a known word; B write then A read-back of the same word.
      add_a(1'b0, 9'h012, 32'd0, 1'b0);
      issue();
      add_b(1'b1, 9'h1FF, 32'h00000055);
      issue();
      add_a(1'b0, 9'h1FF, 32'd0, 1'b0);
      issue();

      // Both requesters streaming back to back.
      add_a(1'b0, 9'h012, 32'd0, 1'b0);
      add_a(1'b1, 9'h030, 32'hA0A0A0A0, 1'b0);
      add_a(1'b0, 9'h030, 32'd0, 1'b0);
      add_b(1'b0, 9'h1FF, 32'd0);
      add_b(1'b1, 9'h031, 32'hB1B1B1B1);
      add_b(1'b0, 9'h031, 32'd0);
      issue();

      // A moves its address mid-access; the latched address must be used.
      add_a(1'b0, 9'h010, 32'd0, 1'b1);
      issue();

      // Reset during the first ACCESS cycle of an A write.
      a_req = 1'b1; a_wr = 1'b1; a_addr = 9'h0AA; a_wdata = 32'hCAFE0001;
      @(posedge clk);
      #1;
      c(ram_write == 1'b1, "pre_reset_write", ram_write, 1);
      #1 clr = 1'b0;
      #1;
      c({ram_read, ram_write, a_ack, b_ack, busy, owner} == 6'b0, "midreset_ctrl",
        {ram_read, ram_write, a_ack, b_ack, busy, owner}, 0);
      c(ram_address == 9'd0 && ram_wdata == 32'd0, "midreset_bus", {ram_address, ram_wdata}, 0);
      c(a_rdata == 32'd0 && b_rdata == 32'd0, "midreset_rdata", {a_rdata, b_rdata}, 0);
      a_req = 1'b0;
      mdl_ptr = 1'b0; mdl_ra = 32'd0; mdl_rb = 32'd0;
      @(negedge clk);
      @(negedge clk);
      clr = 1'b1;
      repeat (4) @(negedge clk);
      add_b(1'b0, 9'h012, 32'd0);
      issue();

      // Randomized rounds.
      for (int r = 0; r < 20; r++) begin
        int mode;
        int na;
        int nb;
        mode = $urandom_range(0, 2);
        na = (mode != 1) ? $urandom_range(1, 3) : 0;
        nb = (mode != 0) ? $urandom_range(1, 3) : 0;
        for (int i = 0; i < na; i++)
          add_a(1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? 9'h1FF : 9'($urandom_range(0, 31)),
                $urandom, 1'b0);
        for (int i = 0; i < nb; i++)
          add_b(1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? 9'h1FF : 9'($urandom_range(0, 31)),
                $urandom);
        issue();
      end
      done_v[g] = 1'b1;
    end
  end

  // Wait (bounded) for all configurations, then report.
  initial begin
    bit all_done;
    all_done = 1'b0;
    for (int w = 0; w < 60000 && !all_done; w++) begin
      @(negedge clk);
      all_done = done_v[0] && done_v[1] && done_v[2];
    end
    chk(all_done, "all_configs_done", all_done, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
